// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one UART transmitter between NREQ byte-stream requesters.
// Optional stalled-grant revoke is compiled in by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb #(
   parameter int NREQ      = 4,
   parameter int DLEN      = 8,
   parameter int MAX_BURST = 16,
   parameter int TIMEOUT   = 1024
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NREQ-1:0]      i_req_valid,
   output logic [NREQ-1:0]      o_req_ready,
   input  logic [NREQ*DLEN-1:0] i_req_data,
   input  logic [NREQ-1:0]      i_req_last,
   output logic                 o_wvalid,
   input  logic                 i_wready,
   output logic [DLEN-1:0]      o_wdata,
   output logic [NREQ-1:0]      o_grant,
   output logic                 o_busy,
   output logic                 o_timeout
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

   if (NREQ < 1 || TIMEOUT < 1) begin : g_bad_param
      $error("uart_tx_arb: NREQ and TIMEOUT must be >= 1");
   end

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   gidx_q, gidx_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [BW-1:0]   burst_q, burst_d;
   logic            pick_found;
   logic [IW-1:0]   pick_idx;
   logic            stall_to;
   logic            xfer;
   logic            burst_hit;
   logic [DLEN-1:0] req_data_a [NREQ];

   always_comb begin
      for (int r = 0; r < NREQ; r++) begin
         req_data_a[r] = i_req_data[r*DLEN +: DLEN];
      end
   end

   // Search ptr+1, ptr+2, ... modulo NREQ; the requester that held the last grant is tried last.
   always_comb begin
      int          cand;
      logic [IW-1:0] cand_idx;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand     = (int'(ptr_q) + i) % NREQ;
         cand_idx = IW'(cand);
         if (!pick_found && i_req_valid[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   assign burst_hit = (MAX_BURST != 0) && (burst_q == BW'(MAX_BURST - 1));

   // Handshakes: a byte moves on a cycle where valid and ready are both high. Once valid is
   // raised it is held with stable data/last until ready; ready never depends on the same
   // lane's valid, so the granted o_req_ready simply mirrors i_wready.
   always_comb begin
      state_d     = state_q;
      gidx_d      = gidx_q;
      ptr_d       = ptr_q;
      burst_d     = burst_q;
      o_wvalid    = 1'b0;
      o_wdata     = '0;
      o_req_ready = '0;
      o_grant     = '0;
      o_busy      = 1'b0;
      xfer        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d = ST_GRANT;
               gidx_d  = pick_idx;
               burst_d = '0;
            end
         end
         ST_GRANT: begin
            o_busy              = 1'b1;
            o_grant[gidx_q]     = 1'b1;
            o_wvalid            = i_req_valid[gidx_q];
            o_wdata             = req_data_a[gidx_q];
            o_req_ready[gidx_q] = i_wready;
            xfer                = i_req_valid[gidx_q] && i_wready;
            if (xfer) begin
               burst_d = burst_q + 1'b1;
            end
            // Last byte and the burst cap on the same transfer still produce a single release.
            if ((xfer && (i_req_last[gidx_q] || burst_hit)) || stall_to) begin
               state_d = ST_IDLE;
               ptr_d   = gidx_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] idle_q, idle_d;

   always_comb begin
      idle_d   = '0;
      stall_to = 1'b0;
      if (state_q == ST_GRANT && !i_req_valid[gidx_q]) begin
         if (idle_q == TW'(TIMEOUT - 1)) begin
            stall_to = 1'b1;
         end else begin
            idle_d = idle_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end

   assign o_timeout = stall_to;
`else
   assign stall_to  = 1'b0;
   assign o_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         gidx_q  <= '0;
         ptr_q   <= LAST_IDX;
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         burst_q <= burst_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: per-requester byte sources, a packet-level arbitration model,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_uart_tx_arb;

   localparam int NREQ      = 4;
   localparam int DLEN      = 8;
   localparam int MAX_BURST = 4;
   localparam int TIMEOUT   = 8;

   logic                 clk = 1'b0;
   logic                 rstn = 1'b0;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*DLEN-1:0] req_data = '0;
   logic [NREQ-1:0]      req_last = '0;
   logic                 wvalid;
   logic                 wready = 1'b0;
   logic [DLEN-1:0]      wdata;
   logic [NREQ-1:0]      grant;
   logic                 busy;
   logic                 timeout;

   uart_tx_arb #(
      .NREQ(NREQ), .DLEN(DLEN), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rstn(rstn),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_data(req_data), .i_req_last(req_last),
      .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata),
      .o_grant(grant), .o_busy(busy), .o_timeout(timeout)
   );

   always #5 clk = ~clk;

   // requester sources: {last, byte} circular stores
   logic [8:0] src_mem [NREQ][256];
   int         src_head [NREQ];
   int         src_tail [NREQ];
   int         valid_pct  = 100;
   int         wready_pct = 100;
   int         force_low  = 0;
   logic [NREQ-1:0] acc = '0;

   // model state: owner -1 means nobody holds the transmitter
   int m_owner = -1, m_owner_nx = -1;
   int m_ptr = NREQ - 1, m_ptr_nx = NREQ - 1;
   int m_cnt = 0, m_cnt_nx = 0;
   int m_idle = 0, m_idle_nx = 0;

   logic [DLEN-1:0] exp_q[$];
   logic [DLEN-1:0] xfer_log[$];
   int grant_log[$];
   int grant_cyc[$];
   int cyc = 0;
   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_byte(input int r, input logic [7:0] d, input logic l);
      src_mem[r][src_tail[r] % 256] = {l, d};
      src_tail[r]++;
   endtask

   task automatic push_pkt(input int r, input int len, input logic [7:0] base);
      for (int i = 0; i < len; i++) push_byte(r, base + 8'(i), (i == len - 1));
   endtask

   task automatic compare_and_model();
      logic [NREQ-1:0] eg, er;
      logic ewv, eto;
      eg = '0; er = '0; ewv = 1'b0; eto = 1'b0;
      if (m_owner >= 0) begin
         eg[m_owner] = 1'b1;
         ewv = req_valid[m_owner];
         er[m_owner] = wready;
`ifdef UART_TX_ARB_TIMEOUT_EN
         eto = !req_valid[m_owner] && (m_idle + 1 == TIMEOUT);
`endif
      end
      chk("grant", 32'(grant), 32'(eg));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      chk("wvalid", 32'(wvalid), 32'(ewv));
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("timeout", 32'(timeout), 32'(eto));
      if (ewv) chk("wdata", 32'(wdata), 32'(req_data[m_owner*DLEN +: DLEN]));
      if (ewv && wready) exp_q.push_back(src_mem[m_owner][src_head[m_owner] % 256][7:0]);
      if (wvalid && wready) begin
         xfer_log.push_back(wdata);
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL xfer_byte: actual=%0h required=none (cycle %0d)", wdata, cyc);
         end else begin
            chk("xfer_byte", 32'(wdata), 32'(exp_q.pop_front()));
         end
      end
      acc = req_valid & req_ready;

      m_owner_nx = m_owner; m_ptr_nx = m_ptr; m_cnt_nx = m_cnt; m_idle_nx = 0;
      if (m_owner < 0) begin
         for (int i = 1; i <= NREQ; i++) begin
            int c;
            c = (m_ptr + i) % NREQ;
            if (m_owner_nx < 0 && req_valid[c]) begin
               m_owner_nx = c;
               m_cnt_nx = 0;
            end
         end
      end else begin
         if (ewv && wready) m_cnt_nx = m_cnt + 1;
         if (!ewv) m_idle_nx = m_idle + 1;
         if ((ewv && wready && (req_last[m_owner] || m_cnt_nx == MAX_BURST)) || eto) begin
            m_owner_nx = -1;
            m_ptr_nx = m_owner;
            m_idle_nx = 0;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      cyc++;
      if (m_owner < 0 && m_owner_nx >= 0) begin
         grant_log.push_back(m_owner_nx);
         grant_cyc.push_back(cyc);
      end
      m_owner = m_owner_nx; m_ptr = m_ptr_nx; m_cnt = m_cnt_nx; m_idle = m_idle_nx;
      for (int r = 0; r < NREQ; r++) begin
         if (acc[r]) src_head[r]++;
         if (acc[r] || !req_valid[r]) begin
            if (src_head[r] != src_tail[r] && $urandom_range(1, 100) <= valid_pct) begin
               req_valid[r] = 1'b1;
               req_data[r*DLEN +: DLEN] = src_mem[r][src_head[r] % 256][7:0];
               req_last[r] = src_mem[r][src_head[r] % 256][8];
            end else begin
               req_valid[r] = 1'b0;
               req_data[r*DLEN +: DLEN] = DLEN'($urandom);
               req_last[r] = 1'($urandom);
            end
         end
      end
      if (force_low > 0) begin
         wready = 1'b0;
         force_low--;
      end else begin
         wready = ($urandom_range(1, 100) <= wready_pct);
      end
      @(negedge clk);
      compare_and_model();
   endtask

   task automatic reset_model();
      m_owner = -1; m_owner_nx = -1; m_ptr = NREQ - 1; m_ptr_nx = NREQ - 1;
      m_cnt = 0; m_cnt_nx = 0; m_idle = 0; m_idle_nx = 0;
      for (int r = 0; r < NREQ; r++) src_head[r] = src_tail[r];
      req_valid = '0;
      acc = '0;
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base, to_at, guard;
      logic [7:0] exp_burst [8];
      for (int r = 0; r < NREQ; r++) begin src_head[r] = 0; src_tail[r] = 0; end
      reset_model();
      repeat (2) @(posedge clk);
      #3 rstn = 1'b1;
      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_wvalid", 32'(wvalid), 32'h0);
      chk("rst_ready", 32'(req_ready), 32'h0);

      // single packet on requester 1
      push_byte(1, 8'h55, 1'b0);
      push_byte(1, 8'hAA, 1'b1);
      cycle(); chk("t2_not_yet", 32'(grant), 32'h0);
      cycle(); chk("t2_grant", 32'(grant), 32'b0010); chk("t2_b0", 32'(wdata), 32'h55);
      cycle(); chk("t2_hold", 32'(grant), 32'b0010); chk("t2_b1", 32'(wdata), 32'hAA);
      cycle(); chk("t2_drop", 32'(grant), 32'h0);

      // asynchronous reset in the middle of a packet
      push_pkt(2, 3, 8'h70);
      repeat (3) cycle();
      #2 rstn = 1'b0;
      #1;
      chk("t1_grant", 32'(grant), 32'h0);
      chk("t1_wvalid", 32'(wvalid), 32'h0);
      chk("t1_busy", 32'(busy), 32'h0);
      reset_model();
      @(posedge clk);
      #3 rstn = 1'b1;
      base = grant_log.size();
      push_pkt(3, 1, 8'h93);
      push_pkt(0, 1, 8'h90);
      repeat (6) cycle();
      chk("t1_count", 32'(grant_log.size() - base), 32'd2);
      if (grant_log.size() >= base + 2) begin
         chk("t1_first", 32'(grant_log[base]), 32'd0);
         chk("t1_second", 32'(grant_log[base+1]), 32'd3);
      end

      // all four contend with one-byte packets
      base = grant_log.size();
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < NREQ; r++) push_pkt(r, 1, 8'(8'h40 + r * 2 + k));
      repeat (20) cycle();
      chk("t3_count", 32'(grant_log.size() - base), 32'd8);
      for (int i = 0; i < 8 && base + i < grant_log.size(); i++) begin
         chk("t3_order", 32'(grant_log[base+i]), 32'(i % NREQ));
         if (i > 0) chk("t3_gap", 32'(grant_cyc[base+i] - grant_cyc[base+i-1]), 32'd2);
      end

      // burst cap splits a 6-byte packet around a waiting requester
      base = grant_log.size();
      xfer_log.delete();
      push_pkt(2, 6, 8'h20);
      push_pkt(3, 2, 8'h30);
      repeat (14) cycle();
      exp_burst[0] = 8'h20; exp_burst[1] = 8'h21; exp_burst[2] = 8'h22; exp_burst[3] = 8'h23;
      exp_burst[4] = 8'h30; exp_burst[5] = 8'h31; exp_burst[6] = 8'h24; exp_burst[7] = 8'h25;
      chk("t4_count", 32'(xfer_log.size()), 32'd8);
      for (int i = 0; i < 8 && i < xfer_log.size(); i++) chk("t4_byte", 32'(xfer_log[i]), 32'(exp_burst[i]));
      chk("t4_grants", 32'(grant_log.size() - base), 32'd3);
      if (grant_log.size() >= base + 3) begin
         chk("t4_g0", 32'(grant_log[base]), 32'd2);
         chk("t4_g1", 32'(grant_log[base+1]), 32'd3);
         chk("t4_g2", 32'(grant_log[base+2]), 32'd2);
      end

      // backpressure holds a byte for five cycles
      xfer_log.delete();
      push_pkt(1, 1, 8'h3C);
      force_low = 6;
      cycle();
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("t5_wvalid", 32'(wvalid), 32'h1);
         chk("t5_wdata", 32'(wdata), 32'h3C);
         chk("t5_ready", 32'(req_ready), 32'h0);
      end
      cycle(); chk("t5_accept", 32'(req_ready), 32'b0010);
      cycle(); chk("t5_release", 32'(busy), 32'h0);
      chk("t5_xfers", 32'(xfer_log.size()), 32'd1);

`ifdef UART_TX_ARB_TIMEOUT_EN
      // stalled grant is revoked on the eighth idle cycle
      base = grant_log.size();
      push_byte(0, 8'h11, 1'b0);
      push_pkt(1, 1, 8'h22);
      cycle(); cycle();
      to_at = 0;
      for (int k = 1; k <= 12; k++) begin
         cycle();
         if (timeout === 1'b1 && to_at == 0) to_at = k;
      end
      chk("t6_to_cycle", 32'(to_at), 32'd8);
      chk("t6_grants", 32'(grant_log.size() - base), 32'd2);
      if (grant_log.size() >= base + 2) chk("t6_next", 32'(grant_log[base+1]), 32'd1);
`endif

      // randomized traffic
      for (int ph = 0; ph < 6; ph++) begin
         valid_pct  = $urandom_range(60, 100);
         wready_pct = $urandom_range(40, 100);
         for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
               int r;
               r = $urandom_range(0, NREQ - 1);
               if (src_tail[r] - src_head[r] < 200) push_pkt(r, $urandom_range(1, 7), 8'($urandom));
            end
            cycle();
         end
      end

      valid_pct = 100;
      wready_pct = 100;
      guard = 0;
      while (guard < 2000) begin
         int pending;
         pending = 0;
         for (int r = 0; r < NREQ; r++) pending += src_tail[r] - src_head[r];
         if (pending == 0 && m_owner < 0 && req_valid == '0) break;
         cycle();
         guard++;
      end
      chk("drain_done", 32'(guard < 2000), 32'h1);
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
